// File: rtl/spi_eeprom_reader.sv
// Hardware EEPROM READ sequencer driving the SPI master register port.
// Issues READ_CMD plus address, then streams the requested bytes on a valid/ready output.
module spi_eeprom_reader #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned LEN_W    = 8,
  parameter logic [7:0]  READ_CMD = 8'h03,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  start_len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              spi_select,
  output logic [2:0]        spi_mem_addr,
  output logic              spi_read_n,
  output logic              spi_write_n,
  output logic [15:0]       spi_data_from_cpu,
  input  logic [15:0]       spi_data_to_cpu,
  input  logic              spi_dataavailable,
  input  logic              spi_readyfordata
);

  localparam int unsigned HDR_W = ADDR_W + 8;
  localparam int unsigned N_HDR = ADDR_W / 8 + 1;
  localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, CLR, SS_ON, HDR, DATA, SS_OFF, FIN} state_t;
  typedef enum logic [2:0] {ST_WAIT_TX, ST_WRITE, ST_WAIT_RX, ST_READ, ST_OUT} step_t;

  state_t             state_q, state_d;
  step_t              step_q, step_d;
  logic [1:0]         ph_q, ph_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [2:0]         hleft_q, hleft_d;
  logic [HDR_W-1:0]   hdr_q, hdr_d;
  logic [7:0]         data_q, data_d;
  logic               error_q, error_d;
  logic               acc_done, acc_on;
  logic               unused_rx_hi;

  assign unused_rx_hi = ^spi_data_to_cpu[15:8];
  // Every bus access is two strobe cycles (ph 0,1) followed by one idle cycle (ph 2).
  assign acc_done = (ph_q == 2'd2);
  assign acc_on   = (ph_q != 2'd2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      step_q  <= ST_WAIT_TX;
      ph_q    <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      hleft_q <= '0;
      hdr_q   <= '0;
      data_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      hleft_q <= hleft_d;
      hdr_q   <= hdr_d;
      data_q  <= data_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    hleft_d = hleft_q;
    hdr_d   = hdr_q;
    data_d  = data_q;
    error_d = error_q;
    unique case (state_q)
      IDLE: if (start) begin
        error_d = 1'b0;
        cnt_d   = start_len;
        hdr_d   = {READ_CMD, start_addr};
        hleft_d = 3'(N_HDR);
        ph_d    = '0;
        state_d = (start_len == '0) ? FIN : CLR;
      end
      CLR, SS_ON, SS_OFF: begin
        if (acc_done) begin
          ph_d = '0;
          unique case (state_q)
            CLR:     state_d = SS_ON;
            SS_ON:   begin state_d = HDR; step_d = ST_WAIT_TX; end
            default: state_d = FIN;
          endcase
        end else begin
          ph_d = ph_q + 2'd1;
        end
      end
      HDR, DATA: begin
        unique case (step_q)
          ST_WAIT_TX: if (spi_readyfordata) begin
            step_d = ST_WRITE;
            ph_d   = '0;
          end
          ST_WRITE: begin
            if (acc_done) begin
              step_d = ST_WAIT_RX;
              wd_d   = '0;
            end else begin
              ph_d = ph_q + 2'd1;
            end
          end
          ST_WAIT_RX: begin
            if (spi_dataavailable) begin
              step_d = ST_READ;
              ph_d   = '0;
            end else if (TIMEOUT != 0 && wd_q == WD_W'(TIMEOUT - 1)) begin
              error_d = 1'b1;
              state_d = SS_OFF;
              ph_d    = '0;
            end else begin
              wd_d = wd_q + WD_W'(1);
            end
          end
          ST_READ: begin
            if (ph_q == 2'd1 && state_q == DATA) data_d = spi_data_to_cpu[7:0];
            if (acc_done) begin
              if (state_q == HDR) begin
                hdr_d   = {hdr_q[HDR_W-9:0], 8'h00};
                hleft_d = hleft_q - 3'd1;
                if (hleft_q == 3'd1) begin
                  state_d = DATA;
                  step_d  = ST_WRITE;
                  ph_d    = '0;
                end else begin
                  step_d = ST_WAIT_TX;
                end
              end else begin
                step_d = ST_OUT;
              end
            end else begin
              ph_d = ph_q + 2'd1;
            end
          end
          ST_OUT: if (out_ready) begin
            // Next tx write only after the handshake, so the rx register never overruns.
            cnt_d = cnt_q - LEN_W'(1);
            ph_d  = '0;
            if (cnt_q == LEN_W'(1)) state_d = SS_OFF;
            else                    step_d  = ST_WRITE;
          end
          default: step_d = ST_WAIT_TX;
        endcase
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    spi_select        = 1'b0;
    spi_mem_addr      = '0;
    spi_read_n        = 1'b1;
    spi_write_n       = 1'b1;
    spi_data_from_cpu = '0;
    if (acc_on) begin
      unique case (state_q)
        CLR: begin
          spi_select = 1'b1; spi_write_n = 1'b0; spi_mem_addr = 3'd2;
        end
        SS_ON: begin
          spi_select = 1'b1; spi_write_n = 1'b0; spi_mem_addr = 3'd3;
          spi_data_from_cpu = 16'h0400;
        end
        SS_OFF: begin
          spi_select = 1'b1; spi_write_n = 1'b0; spi_mem_addr = 3'd3;
        end
        HDR, DATA: begin
          if (step_q == ST_WRITE) begin
            spi_select = 1'b1; spi_write_n = 1'b0; spi_mem_addr = 3'd1;
            if (state_q == HDR) spi_data_from_cpu = {8'h00, hdr_q[HDR_W-1 -: 8]};
          end else if (step_q == ST_READ) begin
            spi_select = 1'b1; spi_read_n = 1'b0;
          end
        end
        default: ;
      endcase
    end
    busy      = (state_q != IDLE) && (state_q != FIN);
    done      = (state_q == FIN);
    error     = error_q;
    out_data  = data_q;
    out_valid = (state_q == DATA) && (step_q == ST_OUT);
  end

endmodule

// File: tb/tb_spi_eeprom_reader.sv
// Self-checking bench for spi_eeprom_reader: SPI master + EEPROM model, bus-protocol
// checker, table-driven requests and hand-written timeout / reset sequences.
`timescale 1ns/1ps
module tb_spi_eeprom_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] start_addr;
  logic [7:0]  start_len;
  logic        busy, done, error, out_valid, out_ready;
  logic [7:0]  out_data;
  logic        spi_select, spi_read_n, spi_write_n;
  logic [2:0]  spi_mem_addr;
  logic [15:0] spi_data_from_cpu, spi_data_to_cpu;
  logic        spi_dataavailable, spi_readyfordata;

  always #5 clk = ~clk;

  spi_eeprom_reader #(.ADDR_W(16), .LEN_W(8), .READ_CMD(8'h03), .TIMEOUT(1023)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .start_len(start_len), .busy(busy), .done(done), .error(error),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .spi_select(spi_select), .spi_mem_addr(spi_mem_addr), .spi_read_n(spi_read_n),
    .spi_write_n(spi_write_n), .spi_data_from_cpu(spi_data_from_cpu),
    .spi_data_to_cpu(spi_data_to_cpu), .spi_dataavailable(spi_dataavailable),
    .spi_readyfordata(spi_readyfordata)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  len;
    int          stall;
    bit          restart;
    logic [7:0]  exp [4];
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mosi_q[$];
  int         windows = 0;
  int         tx_count = 0;
  int         win_base = 0;
  bit         sso = 1'b0;
  bit         no_rrdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] eep(input logic [15:0] a);
    case (a)
      16'h1234: return 8'hA1;
      16'h1235: return 8'hB2;
      16'h1236: return 8'hC3;
      default:  return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // SPI master + EEPROM model; also checks every access is 2 stable cycles then idle.
  task automatic spi_model();
    logic        act, prev_act;
    logic [21:0] tup, prev_tup;
    logic [7:0]  miso;
    logic [15:0] eaddr;
    int          run, lat, idx;
    prev_act = 1'b0; prev_tup = '0; run = 0; lat = 0; miso = '0; eaddr = '0;
    spi_readyfordata = 1'b1; spi_dataavailable = 1'b0; spi_data_to_cpu = '0;
    forever begin
      @(negedge clk or negedge reset_n);
      if (!reset_n) begin
        spi_readyfordata = 1'b1; spi_dataavailable = 1'b0; spi_data_to_cpu = '0;
        sso = 1'b0; lat = 0; prev_act = 1'b0; run = 0;
      end else begin
        act = !spi_read_n || !spi_write_n;
        tup = {spi_select, spi_mem_addr, spi_read_n, spi_write_n, spi_data_from_cpu};
        if (act && prev_act) begin
          check("bus_hold", 64'(tup), 64'(prev_tup));
          run++;
        end
        if (!act && prev_act) check("bus_len", 64'(run), 64'(2));
        if (act && !prev_act) begin
          run = 1;
          check("bus_sel", 64'(spi_select), 64'(1));
          if (!spi_write_n) begin
            case (spi_mem_addr)
              3'd1: begin
                check("tx_in_ss", 64'(sso), 64'(1));
                mosi_q.push_back(spi_data_from_cpu[7:0]);
                tx_count++;
                idx = mosi_q.size() - 1 - win_base;
                if (idx == 1) eaddr[15:8] = spi_data_from_cpu[7:0];
                if (idx == 2) eaddr[7:0]  = spi_data_from_cpu[7:0];
                miso = (idx >= 3) ? eep(eaddr + 16'(idx - 3)) : 8'hFF;
                spi_readyfordata = 1'b0;
                lat = 4;
              end
              3'd2: spi_dataavailable = 1'b0;
              3'd3: begin
                if (spi_data_from_cpu[10] && !sso) begin
                  windows++;
                  win_base = mosi_q.size();
                end
                sso = spi_data_from_cpu[10];
              end
              default: ;
            endcase
          end else if (spi_mem_addr == 3'd0) begin
            spi_dataavailable = 1'b0;
          end
        end
        prev_act = act;
        prev_tup = tup;
        if (lat > 0) begin
          lat--;
          if (lat == 0) begin
            spi_readyfordata = 1'b1;
            if (!no_rrdy) begin
              spi_dataavailable = 1'b1;
              spi_data_to_cpu   = {8'h5C, miso};
            end
          end
        end
      end
    end
  endtask

  task automatic run_req(input vec_t v, input int vi);
    logic [7:0] got[$];
    logic [7:0] held, em;
    int  done_at, stall_left, tx_at_stall, m0, w0, nm;
    bit  stalled, sel_seen, busy_seen;
    m0 = mosi_q.size(); w0 = windows;
    done_at = -1; stall_left = v.stall; stalled = 0; sel_seen = 0; busy_seen = 0;
    held = '0; tx_at_stall = 0;
    no_rrdy = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1; start_addr = v.addr; start_len = v.len;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 0; cyc < 20000 && done_at < 0; cyc++) begin
      @(negedge clk);
      start = (v.restart && cyc == 30);
      if (spi_select) sel_seen = 1;
      if (busy) busy_seen = 1;
      if (done) begin
        done_at = cyc;
        check($sformatf("v%0d_busy_at_done", vi), 64'(busy), 64'(0));
      end
      if (out_valid) begin
        if (got.size() == 0 && stall_left > 0) begin
          if (!stalled) begin
            stalled = 1; held = out_data; tx_at_stall = tx_count;
          end
          out_ready = 1'b0;
          check($sformatf("v%0d_stall_data", vi), 64'(out_data), 64'(held));
          stall_left--;
        end else begin
          if (stalled && got.size() == 0)
            check($sformatf("v%0d_stall_no_tx", vi), 64'(tx_count), 64'(tx_at_stall));
          out_ready = 1'b1;
          got.push_back(out_data);
        end
      end
    end
    start = 1'b0;
    check($sformatf("v%0d_done_seen", vi), 64'(done_at >= 0), 64'(1));
    if (v.len == 0) check($sformatf("v%0d_done_latency", vi), 64'(done_at), 64'(0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("v%0d_quiet", vi), 64'({done, busy, spi_select}), 64'(0));
    end
    check($sformatf("v%0d_n_out", vi), 64'(got.size()), 64'(v.len));
    for (int i = 0; i < got.size() && i < 4; i++)
      check($sformatf("v%0d_byte%0d", vi, i), 64'(got[i]), 64'(v.exp[i]));
    nm = mosi_q.size() - m0;
    check($sformatf("v%0d_mosi_n", vi), 64'(nm), 64'((v.len == 0) ? 0 : 3 + v.len));
    for (int i = 0; i < nm && i < 3 + v.len; i++) begin
      em = (i == 0) ? 8'h03 : (i == 1) ? v.addr[15:8] : (i == 2) ? v.addr[7:0] : 8'h00;
      check($sformatf("v%0d_mosi%0d", vi, i), 64'(mosi_q[m0 + i]), 64'(em));
    end
    check($sformatf("v%0d_ss_windows", vi), 64'(windows - w0), 64'((v.len == 0) ? 0 : 1));
    check($sformatf("v%0d_sel_seen", vi), 64'(sel_seen), 64'(v.len != 0));
    check($sformatf("v%0d_busy_seen", vi), 64'(busy_seen), 64'(v.len != 0));
    check($sformatf("v%0d_ss_released", vi), 64'(sso), 64'(0));
    check($sformatf("v%0d_error", vi), 64'(error), 64'(0));
  endtask

  task automatic run_timeout();
    int cnt, t0;
    bit tx_seen, err_seen, ov, done_seen;
    cnt = 0; t0 = tx_count; tx_seen = 0; err_seen = 0; ov = 0; done_seen = 0;
    no_rrdy = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1; start_addr = 16'h0040; start_len = 8'd1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
      @(negedge clk);
      if (out_valid) ov = 1;
      if (!tx_seen) begin
        if (!spi_write_n && spi_mem_addr == 3'd1) tx_seen = 1;
      end else if (!err_seen) begin
        if (error) begin
          err_seen = 1;
          // idle cycle after the tx write plus 1023 wait cycles
          check("to_wait_cycles", 64'(cnt), 64'(1024));
          check("to_ctrl_off", 64'({spi_write_n, spi_mem_addr, spi_data_from_cpu}),
                64'({1'b0, 3'd3, 16'h0000}));
        end else if (spi_write_n) begin
          cnt++;
        end
      end
      if (done) begin
        done_seen = 1;
        check("to_busy_at_done", 64'(busy), 64'(0));
      end
    end
    check("to_error_set", 64'(err_seen), 64'(1));
    check("to_done", 64'(done_seen), 64'(1));
    check("to_no_valid", 64'(ov), 64'(0));
    check("to_one_tx", 64'(tx_count - t0), 64'(1));
    check("to_ss_released", 64'(sso), 64'(0));
    @(negedge clk);
    check("to_error_sticky", 64'(error), 64'(1));
    no_rrdy = 1'b0;
  endtask

  task automatic run_reset_mid();
    int got;
    bit ok;
    got = 0; ok = 0; out_ready = 1'b1; no_rrdy = 1'b0;
    @(posedge clk); #1 start = 1'b1; start_addr = 16'h0200; start_len = 8'd4;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 0; cyc < 2000 && !ok; cyc++) begin
      @(negedge clk);
      if (out_valid) got++;
      if (got == 2) ok = 1;
    end
    check("rst_two_bytes", 64'(ok), 64'(1));
    repeat (3) @(negedge clk);
    check("rst_pre_busy", 64'(busy), 64'(1));
    #2 reset_n = 1'b0;
    #1 check("rst_outputs",
             64'({busy, done, error, out_valid, out_data, spi_select, spi_mem_addr,
                  spi_read_n, spi_write_n, spi_data_from_cpu}),
             64'({1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 16'h0000}));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t vecs[5];
    vecs[0] = '{addr: 16'h1234, len: 8'd3, stall: 0,   restart: 1'b0, exp: '{8'hA1, 8'hB2, 8'hC3, 8'h00}};
    vecs[1] = '{addr: 16'h0010, len: 8'd2, stall: 500, restart: 1'b0, exp: '{8'h4A, 8'h4B, 8'h00, 8'h00}};
    vecs[2] = '{addr: 16'h00FE, len: 8'd4, stall: 0,   restart: 1'b1, exp: '{8'hA4, 8'hA5, 8'h5A, 8'h5B}};
    vecs[3] = '{addr: 16'hABCD, len: 8'd1, stall: 0,   restart: 1'b0, exp: '{8'h97, 8'h00, 8'h00, 8'h00}};
    vecs[4] = '{addr: 16'h0000, len: 8'd0, stall: 0,   restart: 1'b0, exp: '{8'h00, 8'h00, 8'h00, 8'h00}};

    reset_n = 1'b1; start = 1'b0; start_addr = '0; start_len = '0; out_ready = 1'b1;
    fork spi_model(); join_none
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_state",
             64'({busy, done, error, out_valid, out_data, spi_select, spi_mem_addr,
                  spi_read_n, spi_write_n, spi_data_from_cpu}),
             64'({1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 16'h0000}));
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 5; i++) run_req(vecs[i], i);

    run_timeout();
    run_req(vecs[4], 5);

    run_reset_mid();
    run_req(vecs[0], 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
